// File: rtl/luma_sched.sv
// luma_sched: arbitrates two pixel sources onto one external RGB->luma converter.
// Ports: clk, reset (async low); s0_*/s1_* valid/ready sources; conv_rgb/conv_l converter link;
// m_* show-ahead output stream; stat_clr/stat_px0/stat_px1 beat counters (macro LUMA_SCHED_STATS_EN).
module luma_sched #(
  parameter int CONV_LAT   = 1,
  parameter int FIFO_DEPTH = 4,
  parameter bit LINE_LOCK  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] s0_rgb,
  input  logic        s0_valid,
  input  logic        s0_last,
  output logic        s0_ready,
  input  logic [23:0] s1_rgb,
  input  logic        s1_valid,
  input  logic        s1_last,
  output logic        s1_ready,
  output logic [23:0] conv_rgb,
  input  logic [7:0]  conv_l,
  output logic [7:0]  m_l,
  output logic        m_src,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic        stat_clr,
  output logic [31:0] stat_px0,
  output logic [31:0] stat_px1
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(CONV_LAT + 1);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t state, state_nx;
  logic rr_last;
  logic mid;
  logic credit;
  logic acc0, acc1, acc;
  logic acc_last;
  logic [IW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic [CONV_LAT-1:0] pv, ps, pl;
  logic push, pop;
  logic [AW-1:0] wp, rp;
  logic [9:0] mem [FIFO_DEPTH];
  logic [9:0] head;

  // credit covers everything accepted but not yet popped
  assign credit = (32'(inflight) + 32'(fifo_cnt))
                < 32'(FIFO_DEPTH);
  assign acc0 = s0_valid && s0_ready;
  assign acc1 = s1_valid && s1_ready;
  assign acc = acc0 || acc1;
  assign acc_last = acc1 ? s1_last : s0_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr_last <= 1'b1;
      mid <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        rr_last <= acc1;
        mid <= ~acc_last;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (s0_valid && s1_valid)
          state_nx = rr_last ? G0 : G1;
        else if (s0_valid)
          state_nx = G0;
        else if (s1_valid)
          state_nx = G1;
      end
      G0: begin
        if (acc0) begin
          if (!(LINE_LOCK && !s0_last) && s1_valid)
            state_nx = G1;
        end else if (!(LINE_LOCK && mid)
                     && !s0_valid && s1_valid) begin
          state_nx = G1;
        end
      end
      G1: begin
        if (acc1) begin
          if (!(LINE_LOCK && !s1_last) && s0_valid)
            state_nx = G0;
        end else if (!(LINE_LOCK && mid)
                     && !s1_valid && s0_valid) begin
          state_nx = G0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s0_ready = (state == G0) && credit;
    s1_ready = (state == G1) && credit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      conv_rgb <= '0;
    else if (acc)
      conv_rgb <= acc1 ? s1_rgb : s0_rgb;
  end

  // side-band tags travel alongside the converter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      ps <= '0;
      pl <= '0;
    end else begin
      pv[0] <= acc;
      ps[0] <= acc1;
      pl[0] <= acc_last;
      for (int i = 1; i < CONV_LAT; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
        pl[i] <= pl[i-1];
      end
    end
  end

  assign push = pv[CONV_LAT-1];
  assign m_valid = (fifo_cnt != '0);
  assign pop = m_valid && m_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      fifo_cnt <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      inflight <= inflight + IW'(acc) - IW'(push);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= {conv_l, ps[CONV_LAT-1], pl[CONV_LAT-1]};
  end

  // empty FIFO presents zeros rather than a stale entry
  assign head = m_valid ? mem[rp] : 10'd0;
  assign m_l = head[9:2];
  assign m_src = head[1];
  assign m_last = head[0];

`ifdef LUMA_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_px0 <= '0;
      stat_px1 <= '0;
    end else if (stat_clr) begin
      stat_px0 <= '0;
      stat_px1 <= '0;
    end else begin
      if (acc0) stat_px0 <= stat_px0 + 32'd1;
      if (acc1) stat_px1 <= stat_px1 + 32'd1;
    end
  end
`else
  logic stat_unused;
  assign stat_unused = stat_clr;
  assign stat_px0 = '0;
  assign stat_px1 = '0;
`endif

endmodule
